rtc_timekeeper: RTL

Parametrised, fully synchronous time-of-day counter that replaces the ripple-clocked seconds/minutes/hours chain with one clock domain. It counts seconds from a parametrised prescaler and supports run/pause, a validated time-set strobe, a 12/24-hour display mode and a minute-resolution alarm. It sits between the board clock and the BCD display multiplexer/VGA renderer, and its BCD outputs drop straight into the existing digit paths.

---
 rtl/rtc_timekeeper.sv | 128 ++++++++++++
 1 files changed

// File: rtl/rtc_timekeeper.sv
// Single-clock time-of-day counter: prescaled seconds, validated time load,
// minute-resolution alarm and 12/24-hour BCD display decode.
module rtc_timekeeper #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       run,
    input  logic       mode12,
    input  logic       set_en,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    input  logic       alarm_en,
    input  logic [4:0] alarm_hr,
    input  logic [5:0] alarm_min,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic       pm,
    output logic       tick_1hz,
    output logic       set_err,
    output logic       alarm_hit
);

    localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    logic [PW-1:0] presc_r, presc_s;
    logic [4:0]    hr_r, hr_s, hr12_s;
    logic [5:0]    min_r, min_s;
    logic [5:0]    sec_r, sec_s;
    logic          tick_r, tick_s;
    logic          set_err_r, set_err_s;
    logic          alarm_hit_r, alarm_hit_s;
    logic          set_ok_s;
    logic          adv_s;

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Next-state: load beats advance; advance only on prescaler wrap while running.
    always_comb begin
        presc_s     = presc_r;
        hr_s        = hr_r;
        min_s       = min_r;
        sec_s       = sec_r;
        adv_s       = 1'b0;
        set_ok_s    = set_en && (set_hr <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
        if (set_ok_s) begin
            presc_s = {PW{1'b0}};
            hr_s    = set_hr;
            min_s   = set_min;
            sec_s   = set_sec;
        end else if (run) begin
            if (presc_r == PRESC_LAST) begin
                presc_s = {PW{1'b0}};
                adv_s   = 1'b1;
                if (sec_r == 6'd59) begin
                    sec_s = 6'd0;
                    if (min_r == 6'd59) begin
                        min_s = 6'd0;
                        if (hr_r == 5'd23) begin
                            hr_s = 5'd0;
                        end else begin
                            hr_s = hr_r + 5'd1;
                        end
                    end else begin
                        min_s = min_r + 6'd1;
                    end
                end else begin
                    sec_s = sec_r + 6'd1;
                end
            end else begin
                presc_s = presc_r + PW'(1);
            end
        end else begin
            presc_s = presc_r;
        end
        tick_s      = adv_s;
        set_err_s   = set_en && !set_ok_s;
        // Only an advance can match; out-of-range alarm fields never equal in-range time.
        alarm_hit_s = adv_s && alarm_en && (sec_s == 6'd0) &&
                      (min_s == alarm_min) && (hr_s == alarm_hr);
    end

    // State and pulse registers with synchronous reset.
    always_ff @(posedge sys_clk) begin
        if (rst) begin
            presc_r     <= {PW{1'b0}};
            hr_r        <= 5'd0;
            min_r       <= 6'd0;
            sec_r       <= 6'd0;
            tick_r      <= 1'b0;
            set_err_r   <= 1'b0;
            alarm_hit_r <= 1'b0;
        end else begin
            presc_r     <= presc_s;
            hr_r        <= hr_s;
            min_r       <= min_s;
            sec_r       <= sec_s;
            tick_r      <= tick_s;
            set_err_r   <= set_err_s;
            alarm_hit_r <= alarm_hit_s;
        end
    end

    // 12-hour mapping: midnight and noon both show 12.
    always_comb begin
        if (hr_r == 5'd0) begin
            hr12_s = 5'd12;
        end else if (hr_r <= 5'd12) begin
            hr12_s = hr_r;
        end else begin
            hr12_s = hr_r - 5'd12;
        end
    end

    assign hr_bcd    = bin2bcd({1'b0, (mode12 ? hr12_s : hr_r)});
    assign min_bcd   = bin2bcd(min_r);
    assign sec_bcd   = bin2bcd(sec_r);
    assign pm        = mode12 && (hr_r >= 5'd12);
    assign tick_1hz  = tick_r;
    assign set_err   = set_err_r;
    assign alarm_hit = alarm_hit_r;

endmodule
